wb_decoder_4: RTL and testbench
===============================

// Module: wb_decoder_4
// PURPOSE
//  Wishbone single-master to 4-slave address decoder: the fan-out counterpart of the N:1 arbiters.
//  Sits between an arbiter's wbs_* output and up to 4 peripheral slaves.
//  Per-transfer registered slave select; internal error response for unmapped addresses.
//  Watchdog error response for slaves that never answer.
// PARAMETERS
//  DATA_WIDTH    32              data bus width (8/16/32/64)
//  ADDR_WIDTH    32              address bus width
//  SELECT_WIDTH  DATA_WIDTH/8    byte select width
//  WBSk_ADDR     k<<24 (k=0..3)  base address of slave k
//  WBSk_MSK      32'hFF000000    match mask of slave k; hit = ((adr ^ WBSk_ADDR) & WBSk_MSK)==0
//  TIMEOUT       256             cycles in BUSY before watchdog error; 0 disables watchdog
// PORTS
//  clk         in   1                clock
//  rst_n       in   1                asynchronous reset, active low
//  wbm_adr_i   in   ADDR_WIDTH       master address
//  wbm_dat_i   in   DATA_WIDTH       master write data
//  wbm_dat_o   out  DATA_WIDTH       read data returned to master
//  wbm_we_i    in   1                write enable
//  wbm_sel_i   in   SELECT_WIDTH     byte select
//  wbm_stb_i   in   1                strobe
//  wbm_ack_o   out  1                acknowledge to master
//  wbm_err_o   out  1                error to master
//  wbm_rty_o   out  1                retry to master
//  wbm_cyc_i   in   1                cycle
//  wbs_adr_o   out  4*ADDR_WIDTH     per-slave address; slice k = slave k
//  wbs_dat_o   out  4*DATA_WIDTH     per-slave write data
//  wbs_dat_i   in   4*DATA_WIDTH     per-slave read data
//  wbs_we_o    out  4                per-slave write enable
//  wbs_sel_o   out  4*SELECT_WIDTH   per-slave byte select
//  wbs_stb_o   out  4                per-slave strobe
//  wbs_ack_i   in   4                per-slave acknowledge
//  wbs_err_i   in   4                per-slave error
//  wbs_rty_i   in   4                per-slave retry
//  wbs_cyc_o   out  4                per-slave cycle
// BEHAVIOUR
//  Reset
//  - One clock domain; rst_n is asynchronous and active-low.
//  - Reset forces state IDLE, sel_q=0, wdog=0.
//  - Reset also forces all wbs_cyc_o/wbs_stb_o = 0 and wbm_ack_o/err_o/rty_o = 0.
//  - Reset during BUSY aborts the transfer silently; no response goes to the master.
//  Datapath
//  - adr/dat/we/sel are broadcast to all 4 slices with no gating.
//  - wbm_dat_o = wbs_dat_i[sel_q] when in BUSY, else 0.
//  FSM state IDLE
//  - cyc_i&stb_i with a hit on slave k: sel_q<=k, wdog<=0, go to BUSY.
//  - Lowest index wins when maps overlap.
//  - cyc_i&stb_i with no hit: go to DERR.
//  - No slave is strobed in IDLE, so the first beat of each transfer has +1 cycle latency.
//  FSM state BUSY
//  - wbs_cyc_o[sel_q] = wbs_stb_o[sel_q] = wbm_cyc_i; the strobe is gated by master cyc, not registered.
//  - Master ack/err/rty = slave sel_q ack/err/rty, combinational.
//  - Any of those responses returns the FSM to IDLE next cycle.
//  - Responses from unselected slaves are ignored.
//  - Master drops cyc_i: slave cyc/stb fall in the same cycle; go to IDLE, no response.
//  - Watchdog: wdog increments each BUSY cycle without a response.
//  - When wdog==TIMEOUT-1 and there is still no response: wbm_err_o=1 for that cycle, slave cyc/stb forced 0, go to IDLE.
//  - Slave response and timeout in the same cycle: the slave response wins; err is not added.
//  FSM state DERR
//  - wbm_err_o=1 for exactly one cycle, then IDLE; no slave cyc is asserted.
//  - If the master drops cyc_i in DERR, err is suppressed.
//  Back-to-back transfers
//  - A master holding stb after a response is re-decoded in IDLE.
//  - Minimum transfer cost is 2 cycles (IDLE + BUSY with zero-wait ack).
//  Widths
//  - wdog width = $clog2(TIMEOUT+1); no wrap is possible since the counter is cleared on entering BUSY.
//  - ack/err/rty to the master are mutually exclusive only if the slave's own responses are.
// STRUCTURE
//  - Shared wishbone header holds the FSM encodings: IDLE=2'd0, BUSY=2'd1, DERR=2'd2.
//  - The same header holds the default address-map constants.
//  - One sub-module: wb_watchdog (clear, enable, TIMEOUT param -> expire pulse), reusable by the arbiters.
//  - Address match stays an inline function in this module.
// TESTING
//  - Read slave 2 (adr 0x02000010), slave acks on its 1st BUSY cycle with 0xDEADBEEF -> stb2 high 1 cycle, wbm_ack_o=1, wbm_dat_o=0xDEADBEEF.
//  - Write to unmapped 0x7F000000 (default maps) -> no wbs_cyc_o, wbm_err_o pulses 1 cycle, 2 cycles after stb.
//  - TIMEOUT=8, slave 1 never acks -> wbm_err_o on 8th BUSY cycle, wbs_cyc_o[1] drops that cycle, FSM IDLE.
//  - Slave 0 acks in the same cycle the watchdog expires -> ack only, err=0.
//  - Master drops cyc after 3 BUSY cycles -> wbs_cyc_o[3]=0 same cycle, no response; next stb to slave 0 decodes normally.
//  - rst_n asserted mid-BUSY -> all outputs 0 asynchronously; after release an access to slave 1 completes normally.

Source files
------------

// File: rtl/wb_decoder_4_pkg.sv
// Shared definitions for the 1:4 Wishbone address decoder: FSM encoding,
// default address map and the decode result type.
package wb_decoder_4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DERR = 2'd2
  } state_e;

  localparam int NUM_SLAVES = 4;

  // Slave k owns the 16 MiB window k<<24.
  localparam logic [31:0] WBS0_ADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] WBS1_ADDR_DEF = 32'h0100_0000;
  localparam logic [31:0] WBS2_ADDR_DEF = 32'h0200_0000;
  localparam logic [31:0] WBS3_ADDR_DEF = 32'h0300_0000;
  localparam logic [31:0] WBS_MSK_DEF   = 32'hFF00_0000;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } decode_t;

endpackage

// File: rtl/wb_decoder_4_if.sv
// Bus bundle between one Wishbone master and four slaves; the decoder takes
// the slave modport, the environment driving it takes the master modport.
interface wb_decoder_4_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  // Handshake: a master request is cyc&stb; it completes on the first cycle in
  // which exactly one of ack/err/rty is seen while cyc is still high.
  logic [ADDR_WIDTH-1:0]     wbm_adr_i;
  logic [DATA_WIDTH-1:0]     wbm_dat_i;
  logic [DATA_WIDTH-1:0]     wbm_dat_o;
  logic                      wbm_we_i;
  logic [SELECT_WIDTH-1:0]   wbm_sel_i;
  logic                      wbm_stb_i;
  logic                      wbm_ack_o;
  logic                      wbm_err_o;
  logic                      wbm_rty_o;
  logic                      wbm_cyc_i;
  logic [4*ADDR_WIDTH-1:0]   wbs_adr_o;
  logic [4*DATA_WIDTH-1:0]   wbs_dat_o;
  logic [4*DATA_WIDTH-1:0]   wbs_dat_i;
  logic [3:0]                wbs_we_o;
  logic [4*SELECT_WIDTH-1:0] wbs_sel_o;
  logic [3:0]                wbs_stb_o;
  logic [3:0]                wbs_ack_i;
  logic [3:0]                wbs_err_i;
  logic [3:0]                wbs_rty_i;
  logic [3:0]                wbs_cyc_o;

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o
  );

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o
  );

endinterface

// File: rtl/wb_decoder_4_watchdog.sv
// Response watchdog: counts enabled cycles since the last clear and pulses
// o_expire on the TIMEOUT-th one. TIMEOUT=0 disables it.
module wb_watchdog #(
  parameter int TIMEOUT = 256,
  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [W-1:0] L_LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] r_cnt;

  assign o_expire = (TIMEOUT > 0) && i_enable && (r_cnt == L_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_decoder_4.sv
// Wishbone 1:4 address decoder with registered slave select, internal error
// response for unmapped addresses and a watchdog for silent slaves.
module wb_decoder_4
  import wb_decoder_4_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] WBS0_ADDR    = ADDR_WIDTH'(WBS0_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS1_ADDR    = ADDR_WIDTH'(WBS1_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS2_ADDR    = ADDR_WIDTH'(WBS2_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS3_ADDR    = ADDR_WIDTH'(WBS3_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS0_MSK     = ADDR_WIDTH'(WBS_MSK_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS1_MSK     = ADDR_WIDTH'(WBS_MSK_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS2_MSK     = ADDR_WIDTH'(WBS_MSK_DEF),
  parameter logic [ADDR_WIDTH-1:0] WBS3_MSK     = ADDR_WIDTH'(WBS_MSK_DEF),
  parameter int                    TIMEOUT      = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_decoder_4_if.slave  bus,
  output state_e         o_dbg_state
);

  localparam logic [3:0][ADDR_WIDTH-1:0] L_ADDR = {WBS3_ADDR, WBS2_ADDR, WBS1_ADDR, WBS0_ADDR};
  localparam logic [3:0][ADDR_WIDTH-1:0] L_MSK  = {WBS3_MSK, WBS2_MSK, WBS1_MSK, WBS0_MSK};

  // Walk downwards so the lowest matching index is the one left standing.
  function automatic decode_t decode(input logic [ADDR_WIDTH-1:0] adr);
    decode_t d;
    d = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (((adr ^ L_ADDR[k]) & L_MSK[k]) == '0) begin
        d.hit = 1'b1;
        d.idx = 2'(k);
      end
    end
    return d;
  endfunction

  state_e                r_state;
  state_e                w_next;
  logic [1:0]            r_sel;
  decode_t               w_dec;
  logic                  w_req;
  logic                  w_resp;
  logic                  w_wdog_clr;
  logic                  w_wdog_en;
  logic                  w_expire;
  logic [3:0]            w_cyc;
  logic                  w_ack;
  logic                  w_err;
  logic                  w_rty;
  logic [DATA_WIDTH-1:0] w_dat;

  assign w_req      = bus.wbm_cyc_i & bus.wbm_stb_i;
  assign w_dec      = decode(bus.wbm_adr_i);
  assign w_resp     = bus.wbm_cyc_i &
                      (bus.wbs_ack_i[r_sel] | bus.wbs_err_i[r_sel] | bus.wbs_rty_i[r_sel]);
  assign w_wdog_clr = (r_state == IDLE);
  assign w_wdog_en  = (r_state == BUSY) & bus.wbm_cyc_i & ~w_resp;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wdog_clr),
    .i_enable (w_wdog_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req && w_dec.hit) begin
        r_sel <= w_dec.idx;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_dec.hit ? BUSY : DERR;
      BUSY:    if (!bus.wbm_cyc_i || w_resp || w_expire) w_next = IDLE;
      DERR:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slave strobe follows master cyc combinationally; a watchdog expiry
  // withdraws it in the same cycle the error is reported.
  always_comb begin
    w_cyc = '0;
    w_ack = 1'b0;
    w_err = 1'b0;
    w_rty = 1'b0;
    w_dat = '0;
    case (r_state)
      BUSY: begin
        w_cyc[r_sel] = bus.wbm_cyc_i & ~w_expire;
        w_ack        = bus.wbm_cyc_i & bus.wbs_ack_i[r_sel];
        w_err        = bus.wbm_cyc_i & (bus.wbs_err_i[r_sel] | w_expire);
        w_rty        = bus.wbm_cyc_i & bus.wbs_rty_i[r_sel];
        w_dat        = bus.wbs_dat_i[r_sel*DATA_WIDTH +: DATA_WIDTH];
      end
      DERR:    w_err = bus.wbm_cyc_i;
      default: ;
    endcase
  end

  assign bus.wbs_cyc_o = w_cyc;
  assign bus.wbs_stb_o = w_cyc;
  assign bus.wbm_ack_o = w_ack;
  assign bus.wbm_err_o = w_err;
  assign bus.wbm_rty_o = w_rty;
  assign bus.wbm_dat_o = w_dat;
  assign bus.wbs_adr_o = {4{bus.wbm_adr_i}};
  assign bus.wbs_dat_o = {4{bus.wbm_dat_i}};
  assign bus.wbs_we_o  = {4{bus.wbm_we_i}};
  assign bus.wbs_sel_o = {4{bus.wbm_sel_i}};
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_wb_decoder_4.sv
// Bench for wb_decoder_4: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transfer-level model.
module tb_wb_decoder_4;
  import wb_decoder_4_pkg::*;

  localparam int TMO = 8;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  int     n_checks = 0;
  int     n_fail   = 0;

  // Model: -1 no transfer, 0..3 serving that slave, 4 unmapped-address error.
  int     m_target = -1;
  int     m_age    = 0;

  wb_decoder_4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus ();

  wb_decoder_4 #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge rst_n) m_target = -1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    bus.wbs_rty_i = '0;
  endtask

  task automatic drive_req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_adr_i = adr;
    bus.wbm_we_i  = we;
    bus.wbm_dat_i = dat;
    bus.wbm_sel_i = 4'hF;
  endtask

  task automatic drive_random();
    logic [7:0] top;
    bus.wbm_cyc_i = ($urandom_range(0, 9) != 0);
    bus.wbm_stb_i = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 5))
      0: top = 8'h00;
      1: top = 8'h01;
      2: top = 8'h02;
      3: top = 8'h03;
      4: top = 8'h7F;
      default: top = 8'($urandom);
    endcase
    bus.wbm_adr_i = {top, 24'($urandom)};
    bus.wbm_dat_i = $urandom;
    bus.wbm_we_i  = 1'($urandom);
    bus.wbm_sel_i = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      int r;
      r = $urandom_range(0, 19);
      bus.wbs_ack_i[k] = (r < 3);
      bus.wbs_err_i[k] = (r == 3);
      bus.wbs_rty_i[k] = (r == 4);
      bus.wbs_dat_i[k*32 +: 32] = $urandom;
    end
  endtask

  // ---------------- scoreboard / per-cycle compare ----------------
  always begin : compare
    logic [3:0]  e_cyc;
    logic        e_ack, e_err, e_rty, e_resp, e_tmo;
    logic [31:0] e_dat;
    logic [1:0]  e_state;
    int          k;
    @(negedge clk);
    e_cyc = '0; e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0;
    e_dat = '0; e_state = 2'd0; e_resp = 1'b0; e_tmo = 1'b0;
    if (rst_n && m_target == 4) begin
      e_state = 2'd2;
      e_err   = bus.wbm_cyc_i;
    end else if (rst_n && m_target >= 0) begin
      k       = m_target;
      e_state = 2'd1;
      e_dat   = bus.wbs_dat_i[k*32 +: 32];
      e_resp  = bus.wbm_cyc_i && (bus.wbs_ack_i[k] || bus.wbs_err_i[k] || bus.wbs_rty_i[k]);
      e_tmo   = bus.wbm_cyc_i && !e_resp && (m_age == TMO - 1);
      e_cyc[k] = bus.wbm_cyc_i && !e_tmo;
      e_ack   = bus.wbm_cyc_i && bus.wbs_ack_i[k];
      e_err   = bus.wbm_cyc_i && (bus.wbs_err_i[k] || e_tmo);
      e_rty   = bus.wbm_cyc_i && bus.wbs_rty_i[k];
    end
    check("m_cyc_o", bus.wbs_cyc_o, e_cyc);
    check("m_stb_o", bus.wbs_stb_o, e_cyc);
    check("m_ack",   bus.wbm_ack_o, e_ack);
    check("m_err",   bus.wbm_err_o, e_err);
    check("m_rty",   bus.wbm_rty_o, e_rty);
    check("m_dat",   bus.wbm_dat_o, e_dat);
    check("m_state", dbg_state, e_state);
    check("m_adr_bc", bus.wbs_adr_o, {4{bus.wbm_adr_i}});
    check("m_dat_bc", bus.wbs_dat_o, {4{bus.wbm_dat_i}});
    check("m_we_bc",  bus.wbs_we_o,  {4{bus.wbm_we_i}});
    check("m_sel_bc", bus.wbs_sel_o, {4{bus.wbm_sel_i}});
    @(posedge clk);
    if (!rst_n) begin
      m_target = -1;
    end else if (m_target < 0) begin
      if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
        m_target = (bus.wbm_adr_i[31:24] < 8'd4) ? int'(bus.wbm_adr_i[31:24]) : 4;
        m_age    = 0;
      end
    end else if (m_target == 4) begin
      m_target = -1;
    end else if (!bus.wbm_cyc_i || e_resp || e_tmo) begin
      m_target = -1;
    end else begin
      m_age++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_we_i  = 1'b0;
    bus.wbm_sel_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) next_cycle();
    check("rst_cyc", bus.wbs_cyc_o, 4'b0000);
    check("rst_resp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    // Read slave 2: zero-wait ack on the first BUSY cycle.
    next_cycle();
    drive_req(32'h0200_0010, 1'b0, 32'h0);
    bus.wbs_ack_i = 4'b0100;
    bus.wbs_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rd2_idle_stb", bus.wbs_stb_o, 4'b0000);
    check("rd2_idle_ack", bus.wbm_ack_o, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rd2_stb", bus.wbs_stb_o, 4'b0100);
    check("rd2_ack", bus.wbm_ack_o, 1'b1);
    check("rd2_dat", bus.wbm_dat_o, 32'hDEAD_BEEF);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("rd2_done", dbg_state, 2'd0);

    // Unmapped write: one-cycle internal error, no slave cycle.
    next_cycle();
    drive_req(32'h7F00_0000, 1'b1, 32'h1234_5678);
    @(negedge clk);
    check("unm_idle_err", bus.wbm_err_o, 1'b0);
    check("unm_wdat_bc", bus.wbs_dat_o, {4{32'h1234_5678}});
    next_cycle();
    bus.wbm_stb_i = 1'b0;
    @(negedge clk);
    check("unm_err", bus.wbm_err_o, 1'b1);
    check("unm_cyc", bus.wbs_cyc_o, 4'b0000);
    check("unm_state", dbg_state, 2'd2);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("unm_err_end", bus.wbm_err_o, 1'b0);

    // Slave 1 never answers: watchdog error on the 8th BUSY cycle.
    next_cycle();
    drive_req(32'h0100_0000, 1'b0, 32'h0);
    for (int i = 1; i <= TMO; i++) begin
      next_cycle();
      @(negedge clk);
      check("tmo_cyc", bus.wbs_cyc_o, (i < TMO) ? 4'b0010 : 4'b0000);
      check("tmo_err", bus.wbm_err_o, (i == TMO));
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("tmo_idle", dbg_state, 2'd0);

    // Slave 0 acks exactly when the watchdog would fire: ack wins.
    next_cycle();
    drive_req(32'h0000_0100, 1'b1, 32'hCAFE_0000);
    for (int i = 1; i <= TMO; i++) begin
      next_cycle();
      if (i == TMO) bus.wbs_ack_i = 4'b0001;
      @(negedge clk);
    end
    check("race_ack", bus.wbm_ack_o, 1'b1);
    check("race_err", bus.wbm_err_o, 1'b0);
    check("race_cyc", bus.wbs_cyc_o, 4'b0001);
    next_cycle();
    drive_idle();

    // Master abandons slave 3 after three BUSY cycles, then reads slave 0.
    next_cycle();
    drive_req(32'h0300_0000, 1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("drop_cyc", bus.wbs_cyc_o, 4'b1000);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("drop_cyc_fall", bus.wbs_cyc_o, 4'b0000);
    check("drop_noresp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 3'b000);
    next_cycle();
    drive_req(32'h0000_0040, 1'b0, 32'h0);
    bus.wbs_ack_i = 4'b0001;
    next_cycle();
    @(negedge clk);
    check("drop_next_ack", bus.wbm_ack_o, 1'b1);
    check("drop_next_stb", bus.wbs_stb_o, 4'b0001);
    next_cycle();
    drive_idle();

    // Asynchronous reset in the middle of a BUSY transfer.
    next_cycle();
    drive_req(32'h0100_0000, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", bus.wbs_cyc_o, 4'b0000);
    check("arst_resp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 3'b000);
    check("arst_state", dbg_state, 2'd0);
    drive_idle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
    drive_req(32'h0100_0004, 1'b1, 32'h5555_AAAA);
    bus.wbs_ack_i = 4'b0010;
    next_cycle();
    @(negedge clk);
    check("arst_after_ack", bus.wbm_ack_o, 1'b1);
    check("arst_after_cyc", bus.wbs_cyc_o, 4'b0010);
    next_cycle();
    drive_idle();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      drive_random();
    end
    next_cycle();
    drive_idle();
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
